let_alu: RTL and testbench
==========================

Name: let_alu

Overview:
- Registered 4-operation integer ALU (ADD, SUB, AND, OR) with a one-cycle latency, a valid qualifier and status flags.
- Sits in the datapath between operand-select logic and the writeback stage.
- Required algebraic property: an ADD with operand A equal to zero returns operand B exactly, one cycle later.

Parameters:
- WORD_SIZE, 32, operand and result width in bits (legal range 2 and above).

Ports:
- clk  input  1  rising-edge clock
- rstn  input  1  asynchronous active-low reset
- in_valid  input  1  operands and opcode are valid this cycle
- op  input  2  opcode: 2'b00 ADD, 2'b01 SUB, 2'b10 AND, 2'b11 OR
- in_data  input  WORD_SIZE  operand A
- in_datb  input  WORD_SIZE  operand B
- out_res  output  WORD_SIZE  registered result
- out_valid  output  1  out_res and the flags hold a new result this cycle
- out_zero  output  1  result equals 0
- out_neg  output  1  result MSB
- out_carry  output  1  ADD: carry-out; SUB: borrow (A < B unsigned); AND/OR: 0
- out_ovf  output  1  two's-complement signed overflow for ADD/SUB; AND/OR: 0

Behaviour:
- One clock domain; all outputs are flops clocked on the rising edge of clk.
- Reset: rstn low asynchronously forces out_res=0, out_valid=0 and all flags=0, independent of clk.
  - Outputs stay in the reset state while rstn is low.
  - The first capture happens on the first rising edge after rstn deasserts.
  - Reset asserted mid-operation discards the pending result; no partial update.
- Capture: on a rising edge with in_valid=1, the result for (op, in_data, in_datb) appears on the outputs, and out_valid=1 for exactly that cycle. Latency is 1 cycle.
- Idle: on a rising edge with in_valid=0:
  - out_valid=0;
  - out_res and all flags hold their previous values.
- Back-to-back: in_valid=1 on consecutive cycles gives out_valid=1 on consecutive cycles with no bubble. No backpressure.
- ADD:
  - res = (A+B) mod 2^WORD_SIZE.
  - carry = bit WORD_SIZE of the (WORD_SIZE+1)-bit sum.
  - ovf = A and B have the same MSB and res MSB differs from it.
- ADD identity: if A==0, res must equal B bit-for-bit, with carry=0 and ovf=0. This follows from the arithmetic; it is called out because it is checked explicitly.
- SUB:
  - res = (A-B) mod 2^WORD_SIZE.
  - carry = 1 iff A<B unsigned.
  - ovf = A and B have different MSBs and res MSB differs from A MSB.
- AND / OR: bitwise; carry=0, ovf=0.
- Flags for every op: zero = (res==0); neg = res[WORD_SIZE-1].
- Opcode space is fully decoded; there are no illegal opcodes.
- No internal state besides the output registers.
- X on inputs while in_valid=0 must not propagate into the outputs.

Test Plan:
- Reset:
  - drive in_valid=1, ADD, A=5, B=7, then pulse rstn low mid-cycle → outputs go to 0 immediately and out_valid=0.
  - release rstn and apply ADD 5+7 → next cycle out_res=12, out_valid=1.
- ADD identity: ADD, A=0, B=0xDEADBEEF → next cycle out_res=0xDEADBEEF, carry=0, ovf=0, neg=1, zero=0.
- ADD carry/overflow:
  - 0xFFFFFFFF+1 → res=0, zero=1, carry=1, ovf=0.
  - 0x7FFFFFFF+1 → res=0x80000000, ovf=1, neg=1, carry=0.
- SUB:
  - 3-5 → res=0xFFFFFFFE, carry=1, neg=1.
  - 0x80000000-1 → res=0x7FFFFFFF, ovf=1, carry=0.
  - 9-9 → zero=1.
- Logic ops:
  - AND 0xF0F0F0F0 with 0x0FF00FF0 → 0x00F000F0.
  - OR same operands → 0xFFF0FFF0.
  - both give carry=0, ovf=0.
- Valid/hold: ADD 1+2 with in_valid=1, then 3 idle cycles with random operands and in_valid=0 → out_res stays 3, out_valid pulses high for one cycle only. Then 4 back-to-back valid ops → 4 consecutive valid results in order.

Source files
------------

// File: rtl/let_alu.sv
// let_alu: registered ADD/SUB/AND/OR with zero/neg/carry/ovf flags, one-cycle latency.
// No backpressure: every in_valid beat yields an out_valid beat on the next edge.
module let_alu #(
  parameter int WORD_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  input  logic [1:0]           op,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic [WORD_SIZE-1:0] in_datb,
  output logic [WORD_SIZE-1:0] out_res,
  output logic                 out_valid,
  output logic                 out_zero,
  output logic                 out_neg,
  output logic                 out_carry,
  output logic                 out_ovf
);

  localparam int W = WORD_SIZE;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  logic [W:0]   sum_ext;
  logic [W:0]   diff_ext;
  logic [W-1:0] res_d;
  logic         carry_d;
  logic         ovf_d;

  // Zero-extended subtract: the top bit of the difference is the unsigned borrow.
  always_comb begin
    sum_ext  = {1'b0, in_data} + {1'b0, in_datb};
    diff_ext = {1'b0, in_data} - {1'b0, in_datb};
    res_d    = '0;
    carry_d  = 1'b0;
    ovf_d    = 1'b0;
    case (op)
      OP_ADD: begin
        res_d   = sum_ext[W-1:0];
        carry_d = sum_ext[W];
        ovf_d   = (in_data[W-1] == in_datb[W-1]) && (sum_ext[W-1] != in_data[W-1]);
      end
      OP_SUB: begin
        res_d   = diff_ext[W-1:0];
        carry_d = diff_ext[W];
        ovf_d   = (in_data[W-1] != in_datb[W-1]) && (diff_ext[W-1] != in_data[W-1]);
      end
      OP_AND: res_d = in_data & in_datb;
      OP_OR:  res_d = in_data | in_datb;
      default: res_d = '0;
    endcase
  end

  // Result and flags load only on a valid beat, so idle-cycle operands never reach the outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_res   <= '0;
      out_valid <= 1'b0;
      out_zero  <= 1'b0;
      out_neg   <= 1'b0;
      out_carry <= 1'b0;
      out_ovf   <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_res   <= res_d;
        out_zero  <= (res_d == '0);
        out_neg   <= res_d[W-1];
        out_carry <= carry_d;
        out_ovf   <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_let_alu.sv
// Scoreboarded bench for let_alu: directed plan vectors plus randomized ops against an arithmetic model.
module tb_let_alu;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         n;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         in_valid;
  logic [1:0]   op;
  logic [W-1:0] in_data;
  logic [W-1:0] in_datb;
  logic [W-1:0] out_res;
  logic         out_valid;
  logic         out_zero;
  logic         out_neg;
  logic         out_carry;
  logic         out_ovf;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  exp_t last_out = '0;

  let_alu #(.WORD_SIZE(W)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .op(op),
    .in_data(in_data), .in_datb(in_datb), .out_res(out_res),
    .out_valid(out_valid), .out_zero(out_zero), .out_neg(out_neg),
    .out_carry(out_carry), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  // Reference model: plain wide integer arithmetic on the mathematical values.
  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    longint unsigned ua, ub, full;
    longint sa, sb, ss;
    longint smax, smin;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    smax = (longint'(1) <<< (W - 1)) - 1;
    smin = -(longint'(1) <<< (W - 1));
    e = '0;
    case (o)
      2'd0: begin
        full  = ua + ub;
        e.res = full[W-1:0];
        e.c   = (full >= (64'd1 << W));
        ss    = sa + sb;
        e.v   = (ss > smax) || (ss < smin);
      end
      2'd1: begin
        full  = ua - ub;
        e.res = full[W-1:0];
        e.c   = (ua < ub);
        ss    = sa - sb;
        e.v   = (ss > smax) || (ss < smin);
      end
      2'd2: e.res = a & b;
      default: e.res = a | b;
    endcase
    e.z = (e.res == '0);
    e.n = e.res[W-1];
    return e;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Called just after a rising edge; the beat is captured on the next one.
  task automatic issue_k(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input exp_t e);
    in_valid = 1'b1;
    op       = o;
    in_data  = a;
    in_datb  = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    issue_k(o, a, b, model(o, a, b));
  endtask

  task automatic idle();
    in_valid = 1'b0;
    op       = 2'($urandom);
    in_data  = $urandom;
    in_datb  = $urandom;
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t dut_out();
    return {out_res, out_zero, out_neg, out_carry, out_ovf};
  endfunction

  // Monitor: sampled on the falling edge, away from capture.
  always @(negedge clk) begin
    exp_t got, want;
    got = dut_out();
    n_checks++;
    if (!rstn) begin
      if (got != '0 || out_valid) begin
        n_fail++;
        $display("FAIL reset_hold: got res=%h zncv=%b%b%b%b vld=%b, need all zero",
                 got.res, got.z, got.n, got.c, got.v, out_valid);
      end
      last_out = '0;
    end else if (out_valid) begin
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_valid: got res=%h with no result expected", got.res);
      end else begin
        want = exp_q.pop_front();
        if (got != want) begin
          n_fail++;
          $display("FAIL result: got res=%h zncv=%b%b%b%b, need res=%h zncv=%b%b%b%b",
                   got.res, got.z, got.n, got.c, got.v, want.res, want.z, want.n, want.c, want.v);
        end
      end
      last_out = got;
    end else if (got != last_out) begin
      n_fail++;
      $display("FAIL idle_hold: got res=%h zncv=%b%b%b%b, need held res=%h zncv=%b%b%b%b",
               got.res, got.z, got.n, got.c, got.v,
               last_out.res, last_out.z, last_out.n, last_out.c, last_out.v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rstn     = 1'b0;
    in_valid = 1'b0;
    op       = 2'd0;
    in_data  = '0;
    in_datb  = '0;
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;

    // Captured beat is discarded by an asynchronous mid-cycle reset.
    in_valid = 1'b1; op = 2'd0; in_data = 32'd5; in_datb = 32'd7;
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (out_res != '0 || out_valid || out_zero || out_neg || out_carry || out_ovf) begin
      n_fail++;
      $display("FAIL async_reset: got res=%h vld=%b, need res=0 vld=0", out_res, out_valid);
    end
    @(posedge clk);
    #2;
    rstn = 1'b1;
    exp_q.push_back('{res: 32'd12, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0});
    @(posedge clk);
    #1;

    issue_k(2'd0, 32'h0000_0000, 32'hDEAD_BEEF, '{res: 32'hDEAD_BEEF, z: 1'b0, n: 1'b1, c: 1'b0, v: 1'b0});
    issue_k(2'd0, 32'hFFFF_FFFF, 32'h0000_0001, '{res: 32'h0000_0000, z: 1'b1, n: 1'b0, c: 1'b1, v: 1'b0});
    issue_k(2'd0, 32'h7FFF_FFFF, 32'h0000_0001, '{res: 32'h8000_0000, z: 1'b0, n: 1'b1, c: 1'b0, v: 1'b1});
    issue_k(2'd1, 32'd3,         32'd5,         '{res: 32'hFFFF_FFFE, z: 1'b0, n: 1'b1, c: 1'b1, v: 1'b0});
    issue_k(2'd1, 32'h8000_0000, 32'd1,         '{res: 32'h7FFF_FFFF, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b1});
    issue_k(2'd1, 32'd9,         32'd9,         '{res: 32'h0000_0000, z: 1'b1, n: 1'b0, c: 1'b0, v: 1'b0});
    issue_k(2'd2, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '{res: 32'h00F0_00F0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0});
    issue_k(2'd3, 32'hF0F0_F0F0, 32'h0FF0_0FF0, '{res: 32'hFFF0_FFF0, z: 1'b0, n: 1'b1, c: 1'b0, v: 1'b0});

    // Single pulse then hold across idle cycles with random operands.
    issue_k(2'd0, 32'd1, 32'd2, '{res: 32'd3, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0});
    repeat (3) idle();
    issue_k(2'd0, 32'd10, 32'd20, '{res: 32'd30, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0});
    issue_k(2'd1, 32'd10, 32'd20, '{res: 32'hFFFF_FFF6, z: 1'b0, n: 1'b1, c: 1'b1, v: 1'b0});
    issue_k(2'd2, 32'hFF00, 32'h0FF0, '{res: 32'h0F00, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0});
    issue_k(2'd3, 32'hFF00, 32'h0FF0, '{res: 32'hFFF0, z: 1'b0, n: 1'b0, c: 1'b0, v: 1'b0});
    idle();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
      end else if ($urandom_range(0, 7) == 0) begin
        issue(2'd0, '0, pick_operand());
      end else begin
        issue(2'($urandom), pick_operand(), pick_operand());
      end
    end

    idle();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d results outstanding, need 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
